decoder_mc: RTL

//  Next-generation SWT16 decode stage: parametrised multi-cycle decoder between fetch and IALU.

---
 rtl/swt16_pkg.sv | 53 +++++
 rtl/decoder_mc_if.sv | 55 +++++
 rtl/decoder_op_lut.sv | 76 +++++++
 rtl/decoder_mc.sv | 133 +++++++++++++
 4 files changed

// File: rtl/swt16_pkg.sv
// SWT16 decode-stage shared definitions.
// Holds the opcode and func2 encodings, the IALU operation codes, the operand
// source selector, the decoder FSM states and the decoded-control record
// produced by decoder_op_lut and consumed by decoder_mc.
package swt16_pkg;

    // Primary opcode field, instr[3:0]
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_UTYPE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;

    // U-type sub-function, instr[11:8] of the first word
    localparam logic [3:0] F2_J   = 4'h0;
    localparam logic [3:0] F2_JAL = 4'h1;
    localparam logic [3:0] F2_LI  = 4'h2;

    typedef enum logic [2:0] {
        ALU_PASS2 = 3'd0,
        ALU_ADD   = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_XOR   = 3'd5
    } alu_op_e;

    // Where the two IALU operands come from
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,  // both operands zero
        SRC_REGS   = 2'd1,  // register-file read ports
        SRC_PC_IMM = 2'd2,  // src1 = PC of first word, src2 = immB
        SRC_IMM    = 2'd3   // src1 = 0, src2 = immB
    } src_sel_e;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } state_e;

    typedef struct packed {
        alu_op_e  alu_op;
        src_sel_e src_sel;
        logic     write;
        logic     jump;
        logic     incr_pc;
        logic     is_2word;
        logic     illegal;
    } dec_t;

endpackage

// File: rtl/decoder_mc_if.sv
// Decoder bus bundle: fetch-side handshake, register-file read ports and the
// registered micro-op issued towards the IALU.
//  master : fetch / register file / environment side
//  slave  : decoder_mc
interface decoder_mc_if #(
    parameter int unsigned PMEM_WORD_WIDTH = 16,
    parameter int unsigned IALU_WORD_WIDTH = 16,
    parameter int unsigned REG_IDX_WIDTH   = 4,
    parameter int unsigned PC_WIDTH        = 12
);
    // Fetch side
    logic [PMEM_WORD_WIDTH-1:0] in_instr;
    logic                       in_valid;
    logic [PC_WIDTH-1:0]        in_pc;
    logic                       in_flush;
    logic                       in_stall;
    logic                       out_ready;

    // Register-file read ports (combinational, same cycle)
    logic [REG_IDX_WIDTH-1:0]   rf_rd_idx1;
    logic [REG_IDX_WIDTH-1:0]   rf_rd_idx2;
    logic [IALU_WORD_WIDTH-1:0] rf_rd_data1;
    logic [IALU_WORD_WIDTH-1:0] rf_rd_data2;

    // Issued micro-op
    logic                       out_valid;
    logic [2:0]                 out_alu_op;
    logic [IALU_WORD_WIDTH-1:0] out_src1;
    logic [IALU_WORD_WIDTH-1:0] out_src2;
    logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx;
    logic                       out_act_write_res_to_reg;
    logic                       out_act_jump_to_ialu_res;
    logic                       out_act_incr_pc_is_res;
    logic                       out_illegal;
    logic [PC_WIDTH-1:0]        out_pc;

    modport master (
        output in_instr, in_valid, in_pc, in_flush, in_stall,
        output rf_rd_data1, rf_rd_data2,
        input  out_ready, rf_rd_idx1, rf_rd_idx2,
        input  out_valid, out_alu_op, out_src1, out_src2, out_res_reg_idx,
        input  out_act_write_res_to_reg, out_act_jump_to_ialu_res,
        input  out_act_incr_pc_is_res, out_illegal, out_pc
    );

    modport slave (
        input  in_instr, in_valid, in_pc, in_flush, in_stall,
        input  rf_rd_data1, rf_rd_data2,
        output out_ready, rf_rd_idx1, rf_rd_idx2,
        output out_valid, out_alu_op, out_src1, out_src2, out_res_reg_idx,
        output out_act_write_res_to_reg, out_act_jump_to_ialu_res,
        output out_act_incr_pc_is_res, out_illegal, out_pc
    );

endinterface

// File: rtl/decoder_op_lut.sv
// Combinational opcode lookup for the SWT16 decoder.
//  opcode : instr[OPCODE_WIDTH-1:0] of the instruction's first word
//  func2  : instr[11:8] of the first word (U-type sub-function)
//  dec    : ALU op, operand source, action flags, 2-word and illegal flags
module decoder_op_lut
    import swt16_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 4
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [3:0]              func2,
    output dec_t                    dec
);

    always_comb begin
        dec         = '0;
        dec.alu_op  = ALU_PASS2;
        dec.src_sel = SRC_NONE;
        case (opcode)
            OPCODE_WIDTH'(OP_NOP): ;
            OPCODE_WIDTH'(OP_ADD): begin
                dec.alu_op  = ALU_ADD;
                dec.src_sel = SRC_REGS;
                dec.write   = 1'b1;
            end
            OPCODE_WIDTH'(OP_SUB): begin
                dec.alu_op  = ALU_SUB;
                dec.src_sel = SRC_REGS;
                dec.write   = 1'b1;
            end
            OPCODE_WIDTH'(OP_AND): begin
                dec.alu_op  = ALU_AND;
                dec.src_sel = SRC_REGS;
                dec.write   = 1'b1;
            end
            OPCODE_WIDTH'(OP_OR): begin
                dec.alu_op  = ALU_OR;
                dec.src_sel = SRC_REGS;
                dec.write   = 1'b1;
            end
            OPCODE_WIDTH'(OP_XOR): begin
                dec.alu_op  = ALU_XOR;
                dec.src_sel = SRC_REGS;
                dec.write   = 1'b1;
            end
            OPCODE_WIDTH'(OP_UTYPE): begin
                // Unknown func2 is flagged on the first word; no immB is awaited.
                case (func2)
                    F2_J: begin
                        dec.alu_op   = ALU_ADD;
                        dec.src_sel  = SRC_PC_IMM;
                        dec.jump     = 1'b1;
                        dec.is_2word = 1'b1;
                    end
                    F2_JAL: begin
                        dec.alu_op   = ALU_ADD;
                        dec.src_sel  = SRC_PC_IMM;
                        dec.jump     = 1'b1;
                        dec.write    = 1'b1;
                        dec.incr_pc  = 1'b1;
                        dec.is_2word = 1'b1;
                    end
                    F2_LI: begin
                        dec.alu_op   = ALU_PASS2;
                        dec.src_sel  = SRC_IMM;
                        dec.write    = 1'b1;
                        dec.is_2word = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decoder_mc.sv
// SWT16 multi-cycle decode stage between fetch and IALU.
// Decodes 1-word R-type ALU ops and 2-word U-type ops (J, JAL, LI) into one
// registered micro-op per instruction, one cycle after the last word is accepted.
//  clock : rising-edge clock
//  reset : asynchronous, active-low reset
//  bus   : decoder_mc_if.slave -- fetch handshake (in_instr/in_valid/in_pc/
//          in_flush/in_stall/out_ready), register-file read ports
//          (rf_rd_idx1/2, rf_rd_data1/2) and the issued micro-op (out_*)
module decoder_mc
    import swt16_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH    = 4,
    parameter int unsigned PMEM_WORD_WIDTH = 16,
    parameter int unsigned IALU_WORD_WIDTH = 16,
    parameter int unsigned REG_IDX_WIDTH   = 4,
    parameter int unsigned PC_WIDTH        = 12
) (
    input  logic       clock,
    input  logic       reset,
    decoder_mc_if.slave bus
);

    state_e                     state;
    logic [11:0]                held_instr;  // first word of a U-type, fields [11:0] only
    logic [PC_WIDTH-1:0]        held_pc;

    logic                       accept;
    logic [11:0]                first_word;
    logic [PC_WIDTH-1:0]        first_pc;
    dec_t                       dec;
    logic [IALU_WORD_WIDTH-1:0] imm;
    logic [IALU_WORD_WIDTH-1:0] pc_ext;
    logic [IALU_WORD_WIDTH-1:0] src1_nxt;
    logic [IALU_WORD_WIDTH-1:0] src2_nxt;

    // Flush wins over stall and over the presented word.
    assign bus.out_ready = !bus.in_stall;
    assign accept        = bus.in_valid && !bus.in_stall && !bus.in_flush;

    // Register reads always follow the live word; only meaningful in S_FIRST.
    assign bus.rf_rd_idx1 = REG_IDX_WIDTH'(bus.in_instr[11:8]);
    assign bus.rf_rd_idx2 = REG_IDX_WIDTH'(bus.in_instr[15:12]);

    // In S_IMM the live word is immB; opcode, func2, destination and PC come
    // from the latched first word.
    assign first_word = (state == S_IMM) ? held_instr : bus.in_instr[11:0];
    assign first_pc   = (state == S_IMM) ? held_pc    : bus.in_pc;
    assign imm        = IALU_WORD_WIDTH'(bus.in_instr);
    assign pc_ext     = IALU_WORD_WIDTH'(first_pc);

    decoder_op_lut #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_op_lut (
        .opcode (first_word[OPCODE_WIDTH-1:0]),
        .func2  (first_word[11:8]),
        .dec    (dec)
    );

    always_comb begin
        src1_nxt = '0;
        src2_nxt = '0;
        case (dec.src_sel)
            SRC_REGS: begin
                src1_nxt = bus.rf_rd_data1;
                src2_nxt = bus.rf_rd_data2;
            end
            SRC_PC_IMM: begin
                src1_nxt = pc_ext;
                src2_nxt = imm;
            end
            SRC_IMM:  src2_nxt = imm;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                        <= S_FIRST;
            held_instr                   <= '0;
            held_pc                      <= '0;
            bus.out_valid                <= 1'b0;
            bus.out_alu_op               <= '0;
            bus.out_src1                 <= '0;
            bus.out_src2                 <= '0;
            bus.out_res_reg_idx          <= '0;
            bus.out_act_write_res_to_reg <= 1'b0;
            bus.out_act_jump_to_ialu_res <= 1'b0;
            bus.out_act_incr_pc_is_res   <= 1'b0;
            bus.out_illegal              <= 1'b0;
            bus.out_pc                   <= '0;
        end else if (bus.in_flush || !bus.in_stall) begin
            // Default: a bubble with every output zero. Overridden below when a
            // word is accepted; a flush never gets past this point.
            bus.out_valid                <= 1'b0;
            bus.out_alu_op               <= '0;
            bus.out_src1                 <= '0;
            bus.out_src2                 <= '0;
            bus.out_res_reg_idx          <= '0;
            bus.out_act_write_res_to_reg <= 1'b0;
            bus.out_act_jump_to_ialu_res <= 1'b0;
            bus.out_act_incr_pc_is_res   <= 1'b0;
            bus.out_illegal              <= 1'b0;
            bus.out_pc                   <= '0;

            if (bus.in_flush) begin
                state      <= S_FIRST;
                held_instr <= '0;
                held_pc    <= '0;
            end else if (accept) begin
                if (dec.illegal) begin
                    bus.out_illegal <= 1'b1;
                    bus.out_pc      <= first_pc;
                end else if (state == S_FIRST && dec.is_2word) begin
                    held_instr <= bus.in_instr[11:0];
                    held_pc    <= bus.in_pc;
                    state      <= S_IMM;
                end else begin
                    bus.out_valid                <= 1'b1;
                    bus.out_alu_op               <= dec.alu_op;
                    bus.out_src1                 <= src1_nxt;
                    bus.out_src2                 <= src2_nxt;
                    bus.out_res_reg_idx          <= REG_IDX_WIDTH'(first_word[7:4]);
                    bus.out_act_write_res_to_reg <= dec.write;
                    bus.out_act_jump_to_ialu_res <= dec.jump;
                    bus.out_act_incr_pc_is_res   <= dec.incr_pc;
                    bus.out_pc                   <= first_pc;
                    state                        <= S_FIRST;
                end
            end
        end
    end

endmodule
